// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: Z/V/N flag register, branch condition evaluation,
// flag-hazard stall, fetch redirect handshake, flush pulse, perf counters.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   flag_wr_en, flags_in  ALU flag write {Z,V,N}
//   br_valid, br_is_reg,  branch in decode, BR/B select,
//   cond, pc_plus2,       condition code, branch PC + 2,
//   imm9, reg_target      B word offset, BR target
//   redirect_ready        fetch accepts redirect
//   stall                 combinational decode/fetch hold
//   redirect_valid/pc     registered redirect request and target
//   flush, br_done        registered one-cycle pulses
//   flags_q               architectural flags
//   taken_cnt, stall_cnt  saturating performance counters
module branch_resolve_unit #(
  parameter bit FORWARD = 1'b1,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flag_wr_en,
  input  logic [2:0]       flags_in,
  input  logic             br_valid,
  input  logic             br_is_reg,
  input  logic [2:0]       cond,
  input  logic [15:0]      pc_plus2,
  input  logic [8:0]       imm9,
  input  logic [15:0]      reg_target,
  input  logic             redirect_ready,
  output logic             stall,
  output logic             redirect_valid,
  output logic [15:0]      redirect_pc,
  output logic             flush,
  output logic             br_done,
  output logic [2:0]       flags_q,
  output logic [CNT_W-1:0] taken_cnt,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] HAZ   = 2'd1;
  localparam logic [1:0] REDIR = 2'd2;

  logic [1:0]  state, state_d;
  logic [2:0]  cond_q;
  logic [2:0]  f_eff;
  logic [15:0] target;
  logic        hazard;
  logic        taken_now;
  logic        enter_redir;
  logic        done;
  logic        latch;

  function automatic logic eval_cond(
    input logic [2:0] c,
    input logic [2:0] f
  );
    logic z, v, n, t;
    z = f[2];
    v = f[1];
    n = f[0];
    t = 1'b0;
    unique case (c)
      3'b000: t = !z;
      3'b001: t = z;
      3'b010: t = !z && !n;
      3'b011: t = n;
      3'b100: t = z || (!z && !n);
      3'b101: t = n || z;
      3'b110: t = v;
      3'b111: t = 1'b1;
    endcase
    return t;
  endfunction

  // Bypass the flag write happening this cycle when forwarding is built in.
  assign f_eff = (FORWARD && flag_wr_en) ? flags_in : flags_q;

  // imm9 is a word offset: sign-extend and scale to bytes.
  assign target = br_is_reg ? reg_target
                : pc_plus2 + {{6{imm9[8]}}, imm9, 1'b0};

  // "Always" branches never depend on flags, so they never stall.
  assign hazard = br_valid && flag_wr_en && !FORWARD
                  && (cond != 3'b111);

  assign taken_now = eval_cond(cond, f_eff);
  assign stall = (state == IDLE) && hazard;

  always_comb begin
    state_d     = state;
    enter_redir = 1'b0;
    done        = 1'b0;
    latch       = 1'b0;
    unique case (state)
      IDLE: begin
        if (br_valid) begin
          if (hazard) begin
            latch   = 1'b1;
            state_d = HAZ;
          end else begin
            done = 1'b1;
            if (taken_now) begin
              latch       = 1'b1;
              enter_redir = 1'b1;
              state_d     = REDIR;
            end
          end
        end
      end
      HAZ: begin
        // flags_q now holds the write that caused the hazard.
        done = 1'b1;
        if (eval_cond(cond_q, flags_q)) begin
          enter_redir = 1'b1;
          state_d     = REDIR;
        end else begin
          state_d = IDLE;
        end
      end
      REDIR: begin
        if (redirect_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      cond_q         <= 3'b000;
      flags_q        <= 3'b000;
      redirect_valid <= 1'b0;
      redirect_pc    <= 16'h0000;
      flush          <= 1'b0;
      br_done        <= 1'b0;
      taken_cnt      <= '0;
      stall_cnt      <= '0;
    end else begin
      state          <= state_d;
      redirect_valid <= (state_d == REDIR);
      flush          <= enter_redir;
      br_done        <= done;
      if (flag_wr_en) flags_q <= flags_in;
      if (latch) begin
        cond_q      <= cond;
        redirect_pc <= target;
      end
      if (enter_redir && (taken_cnt != '1))
        taken_cnt <= taken_cnt + CNT_W'(1);
      if (stall && (stall_cnt != '1))
        stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Testbench for branch_resolve_unit: forwarding, non-forwarding and
// narrow-counter instances driven by shared directed stimulus.
module tb_branch_resolve_unit;

  logic        clk;
  logic        rst_a, rst_b;
  logic        flag_wr_en;
  logic [2:0]  flags_in;
  logic        br_valid, br_is_reg;
  logic [2:0]  cond;
  logic [15:0] pc_plus2, reg_target;
  logic [8:0]  imm9;
  logic        redirect_ready;

  logic        stall_a, rv_a, flush_a, done_a;
  logic [15:0] rpc_a;
  logic [2:0]  fq_a;
  logic [15:0] tc_a, sc_a;

  logic        stall_b, rv_b, flush_b, done_b;
  logic [15:0] rpc_b;
  logic [2:0]  fq_b;
  logic [15:0] tc_b, sc_b;

  logic        stall_c, rv_c, flush_c, done_c;
  logic [15:0] rpc_c;
  logic [2:0]  fq_c;
  logic [1:0]  tc_c, sc_c;

  int ntests = 0;
  int nfail  = 0;

  branch_resolve_unit #(.FORWARD(1'b1), .CNT_W(16)) u_a (
    .clk(clk), .rst_n(rst_a), .flag_wr_en(flag_wr_en),
    .flags_in(flags_in), .br_valid(br_valid), .br_is_reg(br_is_reg),
    .cond(cond), .pc_plus2(pc_plus2), .imm9(imm9),
    .reg_target(reg_target), .redirect_ready(redirect_ready),
    .stall(stall_a), .redirect_valid(rv_a), .redirect_pc(rpc_a),
    .flush(flush_a), .br_done(done_a), .flags_q(fq_a),
    .taken_cnt(tc_a), .stall_cnt(sc_a));

  branch_resolve_unit #(.FORWARD(1'b0), .CNT_W(16)) u_b (
    .clk(clk), .rst_n(rst_b), .flag_wr_en(flag_wr_en),
    .flags_in(flags_in), .br_valid(br_valid), .br_is_reg(br_is_reg),
    .cond(cond), .pc_plus2(pc_plus2), .imm9(imm9),
    .reg_target(reg_target), .redirect_ready(redirect_ready),
    .stall(stall_b), .redirect_valid(rv_b), .redirect_pc(rpc_b),
    .flush(flush_b), .br_done(done_b), .flags_q(fq_b),
    .taken_cnt(tc_b), .stall_cnt(sc_b));

  branch_resolve_unit #(.FORWARD(1'b1), .CNT_W(2)) u_c (
    .clk(clk), .rst_n(rst_a), .flag_wr_en(flag_wr_en),
    .flags_in(flags_in), .br_valid(br_valid), .br_is_reg(br_is_reg),
    .cond(cond), .pc_plus2(pc_plus2), .imm9(imm9),
    .reg_target(reg_target), .redirect_ready(redirect_ready),
    .stall(stall_c), .redirect_valid(rv_c), .redirect_pc(rpc_c),
    .flush(flush_c), .br_done(done_c), .flags_q(fq_c),
    .taken_cnt(tc_c), .stall_cnt(sc_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [2:0]  fin;
    logic [2:0]  cnd;
    logic        isr;
    logic [15:0] pc;
    logic [8:0]  imm;
    logic [15:0] rt;
    logic        tk;
    logic [15:0] tgt;
    logic [2:0]  fq;
  } vec_t;

  vec_t vt[12];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_br(input logic [2:0] c, input logic isr,
                          input logic [15:0] pc, input logic [8:0] im,
                          input logic [15:0] rt);
    br_valid   = 1'b1;
    cond       = c;
    br_is_reg  = isr;
    pc_plus2   = pc;
    imm9       = im;
    reg_target = rt;
  endtask

  initial begin
    vt[0]  = '{1'b1, 3'b100, 3'b001, 1'b0, 16'h0010, 9'h1FE, 16'h0000,
               1'b1, 16'h000C, 3'b100};
    vt[1]  = '{1'b0, 3'b000, 3'b000, 1'b0, 16'h0020, 9'h004, 16'h0000,
               1'b0, 16'h0000, 3'b100};
    vt[2]  = '{1'b1, 3'b001, 3'b010, 1'b1, 16'h0000, 9'h000, 16'h4000,
               1'b0, 16'h0000, 3'b001};
    vt[3]  = '{1'b0, 3'b000, 3'b011, 1'b1, 16'h0000, 9'h000, 16'h4000,
               1'b1, 16'h4000, 3'b001};
    vt[4]  = '{1'b0, 3'b000, 3'b101, 1'b0, 16'h0100, 9'h005, 16'h0000,
               1'b1, 16'h010A, 3'b001};
    vt[5]  = '{1'b1, 3'b000, 3'b100, 1'b0, 16'h0200, 9'h100, 16'h0000,
               1'b1, 16'h0000, 3'b000};
    vt[6]  = '{1'b0, 3'b000, 3'b110, 1'b0, 16'h0300, 9'h001, 16'h0000,
               1'b0, 16'h0000, 3'b000};
    vt[7]  = '{1'b1, 3'b010, 3'b110, 1'b1, 16'h0000, 9'h000, 16'h1234,
               1'b1, 16'h1234, 3'b010};
    vt[8]  = '{1'b0, 3'b000, 3'b010, 1'b0, 16'h1000, 9'h0FF, 16'h0000,
               1'b1, 16'h11FE, 3'b010};
    vt[9]  = '{1'b0, 3'b000, 3'b101, 1'b0, 16'h2000, 9'h003, 16'h0000,
               1'b0, 16'h0000, 3'b010};
    vt[10] = '{1'b1, 3'b110, 3'b000, 1'b0, 16'h3000, 9'h003, 16'h0000,
               1'b0, 16'h0000, 3'b110};
    vt[11] = '{1'b0, 3'b000, 3'b111, 1'b1, 16'h0000, 9'h000, 16'hABCD,
               1'b1, 16'hABCD, 3'b110};

    flag_wr_en = 1'b0; flags_in = 3'b000;
    br_valid = 1'b0; br_is_reg = 1'b0; cond = 3'b000;
    pc_plus2 = 16'h0; imm9 = 9'h0; reg_target = 16'h0;
    redirect_ready = 1'b0;
    rst_a = 1'b1; rst_b = 1'b1;
    #2;
    rst_a = 1'b0; rst_b = 1'b0;
    #1;
    chk("rst rv", rv_a, 0);
    chk("rst flush", flush_a, 0);
    chk("rst done", done_a, 0);
    chk("rst flags", fq_a, 0);
    chk("rst rpc", rpc_a, 0);
    chk("rst tcnt", tc_a, 0);
    chk("rst scnt", sc_a, 0);
    tick();
    rst_a = 1'b1;

    // table: forwarding instance, fetch always ready
    for (int i = 0; i < 12; i++) begin
      flag_wr_en = vt[i].wr;
      flags_in   = vt[i].fin;
      drive_br(vt[i].cnd, vt[i].isr, vt[i].pc, vt[i].imm, vt[i].rt);
      redirect_ready = 1'b1;
      #1;
      chk($sformatf("v%0d stall", i), stall_a, 0);
      tick();
      chk($sformatf("v%0d done", i), done_a, 1);
      chk($sformatf("v%0d rv", i), rv_a, vt[i].tk);
      chk($sformatf("v%0d flush", i), flush_a, vt[i].tk);
      chk($sformatf("v%0d flags", i), fq_a, vt[i].fq);
      if (vt[i].tk) chk($sformatf("v%0d rpc", i), rpc_a, vt[i].tgt);
      br_valid = 1'b0;
      flag_wr_en = 1'b0;
      tick();
      chk($sformatf("v%0d rv2", i), rv_a, 0);
      chk($sformatf("v%0d flush2", i), flush_a, 0);
      chk($sformatf("v%0d done2", i), done_a, 0);
    end
    chk("tcnt a", tc_a, 7);
    chk("tcnt sat c", tc_c, 3);
    chk("scnt a", sc_a, 0);

    // target wrap and redirect hold
    redirect_ready = 1'b0;
    drive_br(3'b111, 1'b0, 16'hFFFE, 9'h002, 16'h0);
    tick();
    chk("wrap rv", rv_a, 1);
    chk("wrap rpc", rpc_a, 16'h0002);
    chk("wrap flush", flush_a, 1);
    drive_br(3'b111, 1'b1, 16'h0, 9'h0, 16'h5555);
    flag_wr_en = 1'b1; flags_in = 3'b011;
    #1;
    chk("hold stall", stall_a, 0);
    tick();
    chk("hold1 rv", rv_a, 1);
    chk("hold1 rpc", rpc_a, 16'h0002);
    chk("hold1 flush", flush_a, 0);
    chk("hold1 done", done_a, 0);
    chk("hold1 flags", fq_a, 3'b011);
    flag_wr_en = 1'b0;
    tick();
    chk("hold2 rv", rv_a, 1);
    chk("hold2 rpc", rpc_a, 16'h0002);
    chk("hold2 flush", flush_a, 0);
    br_valid = 1'b0;
    redirect_ready = 1'b1;
    tick();
    chk("hold end rv", rv_a, 0);
    chk("hold tcnt", tc_a, 8);

    // async reset in the middle of a redirect
    redirect_ready = 1'b0;
    drive_br(3'b111, 1'b0, 16'h0040, 9'h001, 16'h0);
    tick();
    chk("pre rst rv", rv_a, 1);
    br_valid = 1'b0;
    #2;
    rst_a = 1'b0;
    #1;
    chk("arst rv", rv_a, 0);
    chk("arst flush", flush_a, 0);
    chk("arst flags", fq_a, 0);
    chk("arst tcnt", tc_a, 0);
    chk("arst rpc", rpc_a, 0);
    tick();
    rst_a = 1'b1;
    rst_b = 1'b1;

    // no-forward instance: hazard then taken
    flag_wr_en = 1'b1; flags_in = 3'b100;
    drive_br(3'b001, 1'b0, 16'h0010, 9'h1FE, 16'h0);
    #1;
    chk("haz stall b", stall_b, 1);
    chk("fwd stall a", stall_a, 0);
    tick();
    chk("haz scnt", sc_b, 1);
    chk("haz rv b", rv_b, 0);
    chk("haz done b", done_b, 0);
    chk("haz flags b", fq_b, 3'b100);
    chk("fwd rv a", rv_a, 1);
    chk("fwd rpc a", rpc_a, 16'h000C);
    flag_wr_en = 1'b0;
    #1;
    chk("haz2 stall b", stall_b, 0);
    tick();
    chk("haz rv2 b", rv_b, 1);
    chk("haz rpc b", rpc_b, 16'h000C);
    chk("haz flush b", flush_b, 1);
    chk("haz done2 b", done_b, 1);
    chk("haz tcnt b", tc_b, 1);
    br_valid = 1'b0;
    redirect_ready = 1'b1;
    tick();
    chk("haz rv3 b", rv_b, 0);
    chk("haz flush3 b", flush_b, 0);

    // always-taken never stalls
    flag_wr_en = 1'b1; flags_in = 3'b000;
    drive_br(3'b111, 1'b1, 16'h0, 9'h0, 16'h0777);
    #1;
    chk("al stall b", stall_b, 0);
    tick();
    chk("al rv b", rv_b, 1);
    chk("al rpc b", rpc_b, 16'h0777);
    br_valid = 1'b0;
    flag_wr_en = 1'b0;
    tick();

    // hazard resolving not taken
    flag_wr_en = 1'b1; flags_in = 3'b000;
    drive_br(3'b001, 1'b0, 16'h0100, 9'h002, 16'h0);
    #1;
    chk("nt stall b", stall_b, 1);
    tick();
    flag_wr_en = 1'b0;
    br_valid = 1'b0;
    tick();
    chk("nt done b", done_b, 1);
    chk("nt rv b", rv_b, 0);
    chk("nt flush b", flush_b, 0);
    chk("nt scnt b", sc_b, 2);
    tick();
    chk("nt done2 b", done_b, 0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
